// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM pipeline SRAM arbiter.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } arb_gnt_e;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

    // Wait counter needs to hold WAIT_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the IF port, data port and SRAM pins seen by the arbiter.
interface sram_arbiter_if #(
    parameter int SRAM_AW = 18
) ();
    logic               if_req;
    logic [31:0]        if_addr;
    logic [31:0]        if_rdata;
    logic               if_ready;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic               pipe_freeze;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, pipe_freeze,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, pipe_freeze,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_arbiter_wait_counter.sv
// Loadable down-counter timing the SRAM access window; zero flags the last cycle.
module sram_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM controller shared by the IF and MEM stages.
// Optional SRAM_ARB_RR_EN selects round-robin tie-breaking instead of data-port priority.
module sram_arbiter
    import arm_mem_pkg::*;
#(
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);
    localparam int             CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e         state_q;
    arb_gnt_e           gnt_q;
    arb_gnt_e           gnt_d;
    logic               write_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        if_rdata_q;
    logic [31:0]        mem_rdata_q;
    logic               if_ready_q;
    logic               mem_ready_q;
    logic               we_n_q;
    logic               oe_n_q;
`ifdef SRAM_ARB_RR_EN
    arb_gnt_e           last_gnt_q;
`endif

    logic               if_any;
    logic               mem_any;
    logic               cnt_zero;
    logic [31:0]        mem_off;
    logic [SRAM_AW-1:0] if_word;
    logic [SRAM_AW-1:0] mem_word;
    logic               unused_addr_bits;

    assign if_any   = bus.if_req;
    assign mem_any  = bus.mem_r_en | bus.mem_w_en;
    assign mem_off  = bus.mem_addr - MEM_BASE;
    assign if_word  = bus.if_addr[SRAM_AW+1:2];
    assign mem_word = mem_off[SRAM_AW+1:2];
    assign unused_addr_bits = ^{bus.if_addr[31:SRAM_AW+2], bus.if_addr[1:0],
                                mem_off[31:SRAM_AW+2], mem_off[1:0]};

    always_comb begin
        gnt_d = mem_any ? GNT_MEM : GNT_IF;
`ifdef SRAM_ARB_RR_EN
        if (if_any && mem_any) begin
            gnt_d = (last_gnt_q == GNT_MEM) ? GNT_IF : GNT_MEM;
        end
`endif
    end

    sram_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .load    ((state_q == IDLE) && (if_any || mem_any)),
        .load_val(CNT_LOAD),
        .en      ((state_q == ACCESS) && !cnt_zero),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
`ifdef SRAM_ARB_RR_EN
            last_gnt_q  <= GNT_IF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_any || mem_any) begin
                        state_q <= ACCESS;
                        gnt_q   <= gnt_d;
`ifdef SRAM_ARB_RR_EN
                        last_gnt_q <= gnt_d;
`endif
                        if (gnt_d == GNT_MEM) begin
                            addr_q  <= mem_word;
                            wdata_q <= bus.mem_wdata;
                            write_q <= bus.mem_w_en;
                            we_n_q  <= ~bus.mem_w_en;
                            oe_n_q  <= bus.mem_w_en;
                        end else begin
                            addr_q  <= if_word;
                            write_q <= 1'b0;
                            we_n_q  <= 1'b1;
                            oe_n_q  <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // The access always runs to completion; a dropped read just loses its data.
                    if (cnt_zero) begin
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (gnt_q == GNT_IF) begin
                            if (bus.if_req) begin
                                if_rdata_q <= bus.sram_rdata;
                                if_ready_q <= 1'b1;
                            end
                        end else if (write_q) begin
                            mem_ready_q <= 1'b1;
                        end else if (bus.mem_r_en) begin
                            mem_rdata_q <= bus.sram_rdata;
                            mem_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_ready    = if_ready_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.mem_ready   = mem_ready_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_wdata  = wdata_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.pipe_freeze = ~rst & ((bus.if_req & ~if_ready_q) | (mem_any & ~mem_ready_q));
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a small behavioural SRAM.
module tb_sram_arbiter;
    import arm_mem_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] sram_mem [0:255];

    sram_arbiter_if #(.SRAM_AW(18)) bus ();

    sram_arbiter #(
        .SRAM_AW    (18),
        .WAIT_CYCLES(4),
        .MEM_BASE   (32'd1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.sram_rdata = bus.sram_oe_n ? 32'h0 : sram_mem[bus.sram_addr[7:0]];

    always @(posedge clk) begin
        if (!bus.sram_we_n) sram_mem[bus.sram_addr[7:0]] = bus.sram_wdata;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 ns, required to finish earlier");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        n_checks++; if (bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready: got %b expected 0", bus.if_ready); end
        n_checks++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready: got %b expected 0", bus.mem_ready); end
        n_checks++; if (bus.if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h expected 0", bus.if_rdata); end
        n_checks++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h expected 0", bus.mem_rdata); end
        n_checks++; if (bus.sram_addr !== 18'h0) begin n_fail++; $display("FAIL reset_sram_addr: got %h expected 0", bus.sram_addr); end
        n_checks++; if (bus.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_sram_wdata: got %h expected 0", bus.sram_wdata); end
        n_checks++; if (bus.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b expected 1", bus.sram_we_n); end
        n_checks++; if (bus.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n: got %b expected 1", bus.sram_oe_n); end
        n_checks++; if (bus.pipe_freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %b expected 0", bus.pipe_freeze); end
        bus.if_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset: all outputs at reset values, freeze held low");
    endtask

    task automatic test_if_read();
        int rdy_cyc;
        rdy_cyc = -1;
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        for (int c = 0; c <= 6; c++) begin
            #1;
            n_checks++; if (bus.sram_oe_n !== ((c >= 1 && c <= 4) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL if_read_oe_n c%0d: got %b", c, bus.sram_oe_n); end
            n_checks++; if (bus.pipe_freeze !== ((c <= 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL if_read_freeze c%0d: got %b", c, bus.pipe_freeze); end
            n_checks++; if (bus.if_ready !== ((c == 5) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL if_read_ready c%0d: got %b", c, bus.if_ready); end
            if (c >= 1 && c <= 4) begin
                n_checks++; if (bus.sram_addr !== 18'd4) begin n_fail++; $display("FAIL if_read_addr c%0d: got %0d expected 4", c, bus.sram_addr); end
            end
            if (bus.if_ready) begin
                rdy_cyc = c;
                n_checks++; if (bus.if_rdata !== 32'hE3A01005) begin n_fail++; $display("FAIL if_read_data: got %h expected e3a01005", bus.if_rdata); end
                bus.if_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("if_read: addr=0x10 ready_cycle=%0d rdata=%h", rdy_cyc, bus.if_rdata);
    endtask

    task automatic test_write_read();
        int we_cnt;
        int rdy_cyc;
        we_cnt  = 0;
        rdy_cyc = -1;
        @(posedge clk); #1;
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = 32'd1028;
        bus.mem_wdata = 32'hDEADBEEF;
        for (int c = 0; c <= 7; c++) begin
            #1;
            if (!bus.sram_we_n) begin
                we_cnt++;
                n_checks++; if (bus.sram_addr !== 18'd1) begin n_fail++; $display("FAIL write_addr c%0d: got %0d expected 1", c, bus.sram_addr); end
                n_checks++; if (bus.sram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_wdata c%0d: got %h expected deadbeef", c, bus.sram_wdata); end
            end
            if (bus.mem_ready) begin
                if (rdy_cyc < 0) rdy_cyc = c;
                bus.mem_w_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (we_cnt != 4) begin n_fail++; $display("FAIL write_we_cycles: got %0d expected 4", we_cnt); end
        n_checks++; if (rdy_cyc != 5) begin n_fail++; $display("FAIL write_ready_cycle: got %0d expected 5", rdy_cyc); end
        n_checks++; if (sram_mem[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_mem: got %h expected deadbeef", sram_mem[1]); end
        $display("write: addr=1028 wdata=deadbeef we_cycles=%0d ready_cycle=%0d", we_cnt, rdy_cyc);

        rdy_cyc = -1;
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 32'd1028;
        for (int c = 0; c <= 7; c++) begin
            #1;
            if (bus.mem_ready) begin
                if (rdy_cyc < 0) rdy_cyc = c;
                n_checks++; if (bus.mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_back_data: got %h expected deadbeef", bus.mem_rdata); end
                bus.mem_r_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (rdy_cyc != 5) begin n_fail++; $display("FAIL read_back_cycle: got %0d expected 5", rdy_cyc); end
        $display("read: addr=1028 ready_cycle=%0d rdata=%h", rdy_cyc, bus.mem_rdata);
    endtask

    task automatic test_arbitration();
        int if_cyc;
        int mem_cyc;
        int exp_if_cyc;
        int exp_mem_cyc;
        logic [17:0] exp_first_addr;
`ifdef SRAM_ARB_RR_EN
        // Previous grant was the data port, so the IF port wins this tie.
        exp_if_cyc = 5; exp_mem_cyc = 11; exp_first_addr = 18'd4;
`else
        exp_if_cyc = 11; exp_mem_cyc = 5; exp_first_addr = 18'd2;
`endif
        if_cyc  = -1;
        mem_cyc = -1;
        @(posedge clk); #1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 32'd1032;
        for (int c = 0; c <= 13; c++) begin
            #1;
            if (c == 1) begin
                n_checks++; if (bus.sram_addr !== exp_first_addr) begin n_fail++; $display("FAIL arb_first_addr: got %0d expected %0d", bus.sram_addr, exp_first_addr); end
            end
            if (c == 6) begin
                n_checks++; if (bus.pipe_freeze !== 1'b1) begin n_fail++; $display("FAIL arb_freeze_between: got %b expected 1", bus.pipe_freeze); end
            end
            if (bus.mem_ready) begin
                if (mem_cyc < 0) mem_cyc = c;
                n_checks++; if (bus.mem_rdata !== 32'h11112222) begin n_fail++; $display("FAIL arb_mem_data: got %h expected 11112222", bus.mem_rdata); end
                bus.mem_r_en = 1'b0;
            end
            if (bus.if_ready) begin
                if (if_cyc < 0) if_cyc = c;
                n_checks++; if (bus.if_rdata !== 32'hE3A01005) begin n_fail++; $display("FAIL arb_if_data: got %h expected e3a01005", bus.if_rdata); end
                bus.if_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (mem_cyc != exp_mem_cyc) begin n_fail++; $display("FAIL arb_mem_cycle: got %0d expected %0d", mem_cyc, exp_mem_cyc); end
        n_checks++; if (if_cyc != exp_if_cyc) begin n_fail++; $display("FAIL arb_if_cycle: got %0d expected %0d", if_cyc, exp_if_cyc); end
        $display("arbitration: tie mem_ready_cycle=%0d if_ready_cycle=%0d", mem_cyc, if_cyc);
    endtask

    task automatic test_back_to_back();
        int r1;
        int r2;
        r1 = -1;
        r2 = -1;
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        for (int c = 0; c <= 13; c++) begin
            #1;
            if (c == 6) begin
                n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d expected %0d", dut.state_q, IDLE); end
                n_checks++; if (bus.sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_oe_n: got %b expected 1", bus.sram_oe_n); end
            end
            if (c == 7) begin
                n_checks++; if (bus.sram_addr !== 18'd5) begin n_fail++; $display("FAIL b2b_second_addr: got %0d expected 5", bus.sram_addr); end
            end
            if (bus.if_ready) begin
                if (r1 < 0) begin
                    r1 = c;
                    n_checks++; if (bus.if_rdata !== 32'hE3A01005) begin n_fail++; $display("FAIL b2b_data1: got %h expected e3a01005", bus.if_rdata); end
                    bus.if_addr = 32'h14;
                end else begin
                    r2 = c;
                    n_checks++; if (bus.if_rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL b2b_data2: got %h expected 55aa55aa", bus.if_rdata); end
                    bus.if_req = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (r1 != 5 || r2 != 11) begin n_fail++; $display("FAIL b2b_cycles: got %0d,%0d expected 5,11", r1, r2); end
        $display("back_to_back: ready cycles %0d and %0d", r1, r2);
    endtask

    task automatic test_flush();
        logic seen_ready;
        seen_ready = 1'b0;
        @(posedge clk); #1;
        bus.mem_r_en = 1'b1;
        bus.mem_addr = 32'd1036;
        for (int c = 0; c <= 8; c++) begin
            if (c == 3) bus.mem_r_en = 1'b0;
            #1;
            if (bus.mem_ready) seen_ready = 1'b1;
            if (c == 4) begin
                n_checks++; if (bus.sram_oe_n !== 1'b0) begin n_fail++; $display("FAIL flush_oe_n_c4: got %b expected 0", bus.sram_oe_n); end
                n_checks++; if (bus.pipe_freeze !== 1'b0) begin n_fail++; $display("FAIL flush_freeze_c4: got %b expected 0", bus.pipe_freeze); end
            end
            if (c == 5) begin
                n_checks++; if (dut.state_q !== DONE) begin n_fail++; $display("FAIL flush_done_c5: got %0d expected %0d", dut.state_q, DONE); end
            end
            if (c == 6) begin
                n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL flush_idle_c6: got %0d expected %0d", dut.state_q, IDLE); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b expected 0", seen_ready); end
        n_checks++; if (bus.mem_rdata !== 32'h11112222) begin n_fail++; $display("FAIL flush_rdata_hold: got %h expected 11112222", bus.mem_rdata); end
        $display("flush: read dropped, ready_seen=%b rdata=%h", seen_ready, bus.mem_rdata);
    endtask

    task automatic test_reset_mid();
        logic seen_ready;
        seen_ready = 1'b0;
        @(posedge clk); #1;
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = 32'd1044;
        bus.mem_wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_before: got %b expected 0", bus.sram_we_n); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.pipe_freeze !== 1'b0) begin n_fail++; $display("FAIL rstmid_freeze: got %b expected 0", bus.pipe_freeze); end
        @(posedge clk); #1;
        n_checks++; if (bus.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_n: got %b expected 1", bus.sram_we_n); end
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, IDLE); end
        n_checks++; if (bus.if_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b%b expected 00", bus.if_ready, bus.mem_ready); end
        n_checks++; if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.mem_rdata); end
        bus.mem_w_en = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) seen_ready = 1'b1;
        end
        n_checks++; if (seen_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_ready: got %b expected 0", seen_ready); end
        $display("reset_mid_write: we_n=%b state=%0d after reset edge", bus.sram_we_n, dut.state_q);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.mem_r_en  = 1'b0;
        bus.mem_w_en  = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
        sram_mem[2] = 32'h11112222;
        sram_mem[3] = 32'h33334444;
        sram_mem[4] = 32'hE3A01005;
        sram_mem[5] = 32'h55AA55AA;

        test_reset();
        test_if_read();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
